mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arb_pick.sv | 26 ++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the I-cache/D-cache memory arbiter: FSM states and owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection; MEM_ARB_ROUND_ROBIN_EN selects round-robin ties,
// otherwise the D-cache wins every tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   icReq,
    input  logic   dcReq,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  owner_t lastOwner,
`endif
    output owner_t owner
);

    always_comb begin
        owner = OWN_DC;
        if (icReq && !dcReq) begin
            owner = OWN_IC;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (icReq && dcReq) begin
            owner = (lastOwner == OWN_DC) ? OWN_IC : OWN_DC;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter (I-cache reads, D-cache reads/writes).
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin ties instead of D-cache priority.
//
// state | meaning
// IDLE  | no transaction; sample requests, pick owner, latch its command
// GRANT | mem_req high with latched command; wait for mem_done, capture data
// RESP  | one-cycle done pulse to the owner
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_wr,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              busy
);

    arbState_t         state, stateNext;
    owner_t            owner, pickOwner;
    logic              latchCmd, captureData;
    logic [DATA_W-1:0] rdataReg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t            lastOwner;
`endif

    mem_arb_pick uPick (
        .icReq     (ic_req),
        .dcReq     (dc_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .lastOwner (lastOwner),
`endif
        .owner     (pickOwner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        latchCmd    = 1'b0;
        captureData = 1'b0;
        case (state)
            IDLE: begin
                if (ic_req || dc_req) begin
                    latchCmd  = 1'b1;
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                if (mem_done) begin
                    captureData = 1'b1;
                    stateNext   = RESP;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Memory sees only the latched copy, so requester fields may move during GRANT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IC;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdataReg  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            lastOwner <= OWN_IC;
`endif
        end else begin
            if (latchCmd) begin
                owner <= pickOwner;
                if (pickOwner == OWN_DC) begin
                    mem_wr    <= dc_wr;
                    mem_addr  <= dc_addr;
                    mem_wdata <= dc_wdata;
                end else begin
                    mem_wr    <= 1'b0;
                    mem_addr  <= ic_addr;
                    mem_wdata <= '0;
                end
            end
            if (captureData) begin
                rdataReg  <= mem_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                lastOwner <= owner;
`endif
            end
        end
    end

    assign mem_req  = (state == GRANT);
    assign busy     = (state != IDLE);
    assign ic_done  = (state == RESP) && (owner == OWN_IC);
    assign dc_done  = (state == RESP) && (owner == OWN_DC);
    assign ic_rdata = rdataReg;
    assign dc_rdata = rdataReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected commands, a monitor
// predicts grant order from the arbitration rules and checks memory traffic and done pulses.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int IC = 0;
    localparam int DC = 1;
    localparam int PH_FREE = 0;
    localparam int PH_CMD  = 1;
    localparam int PH_RESP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_done;
    logic [DW-1:0] ic_rdata;
    logic          dc_req = 1'b0;
    logic          dc_wr = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [DW-1:0] dc_wdata = '0;
    logic          dc_done;
    logic [DW-1:0] dc_rdata;
    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_done = 1'b0;
    logic          busy;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_done   (ic_done),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_wr     (dc_wr),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_done   (dc_done),
        .dc_rdata  (dc_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    cmd_t          icExp[$];
    cmd_t          dcExp[$];
    logic [DW-1:0] refMem [logic [AW-1:0]];
    logic [DW-1:0] memArr [logic [AW-1:0]];
    int            svcOrder[$];
    int            nCmp = 0;
    int            nFail = 0;
    int            icDoneCnt = 0;
    int            dcDoneCnt = 0;
    int            icLat = 0;
    int            dcLat = 0;
    logic [DW-1:0] icRdLast = '0;
    bit            memAuto = 1'b1;
    int            forcedStall = -1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (!ok) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] initData(input logic [AW-1:0] a);
        return DW'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [DW-1:0] refRead(input logic [AW-1:0] a);
        return refMem.exists(a) ? refMem[a] : initData(a);
    endfunction

    function automatic logic [AW-1:0] randAddr();
        return AW'($urandom_range(0, 15) * 2);
    endfunction

    // Shared memory: random stall, then one-cycle mem_done.
    initial begin : memory
        int stall;
        bit waiting;
        stall = 0;
        waiting = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!memAuto) begin
                waiting = 1'b0;
                continue;
            end
            mem_done = 1'b0;
            if (rst || !mem_req) begin
                waiting = 1'b0;
                continue;
            end
            if (!waiting) begin
                waiting = 1'b1;
                stall = (forcedStall >= 0) ? forcedStall : int'($urandom_range(0, 3));
            end
            if (stall == 0) begin
                mem_done = 1'b1;
                waiting  = 1'b0;
                if (mem_wr) begin
                    memArr[mem_addr] = mem_wdata;
                    mem_rdata = DW'($urandom);
                end else begin
                    mem_rdata = memArr.exists(mem_addr) ? memArr[mem_addr] : initData(mem_addr);
                end
            end else begin
                stall--;
            end
        end
    end

    // Monitor: reference arbitration plus command/response checking.
    initial begin : monitor
        int            ph;
        int            curOwner;
        int            cmdCycles;
        cmd_t          cur;
        logic [DW-1:0] expData;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        int            lastServed;
        lastServed = IC;
`endif
        ph = PH_FREE;
        curOwner = IC;
        cmdCycles = 0;
        cur = '{wr: 1'b0, addr: '0, wdata: '0};
        expData = '0;
        forever begin
            @(negedge clk);
            if (ic_done) icDoneCnt++;
            if (dc_done) dcDoneCnt++;
            if (rst) begin
                check({mem_req, mem_wr, ic_done, dc_done, busy} == 5'b0, "reset_ctrl",
                      32'({mem_req, mem_wr, ic_done, dc_done, busy}), 32'd0);
                check((mem_addr | mem_wdata | ic_rdata | dc_rdata) == '0, "reset_data",
                      32'(mem_addr | mem_wdata | ic_rdata | dc_rdata), 32'd0);
                ph = PH_FREE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                lastServed = IC;
`endif
                continue;
            end
            case (ph)
                PH_FREE: begin
                    check({ic_done, dc_done} == 2'b00, "idle_no_done", 32'({ic_done, dc_done}), 32'd0);
                    check(busy == 1'b0, "idle_busy", 32'(busy), 32'd0);
                    if (ic_req || dc_req) begin
                        if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                            curOwner = (lastServed == DC) ? IC : DC;
`else
                            curOwner = DC;
`endif
                        end else begin
                            curOwner = dc_req ? DC : IC;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        lastServed = curOwner;
`endif
                        if (curOwner == DC) begin
                            check(dcExp.size() > 0, "dc_exp_avail", 32'(dcExp.size()), 32'd1);
                            if (dcExp.size() > 0) cur = dcExp.pop_front();
                        end else begin
                            check(icExp.size() > 0, "ic_exp_avail", 32'(icExp.size()), 32'd1);
                            if (icExp.size() > 0) cur = icExp.pop_front();
                        end
                        ph = PH_CMD;
                        cmdCycles = 0;
                    end
                end
                PH_CMD: begin
                    check(mem_req == 1'b1 && busy == 1'b1, "grant_req_busy", 32'({mem_req, busy}), 32'd3);
                    check(mem_addr == cur.addr, "mem_addr", 32'(mem_addr), 32'(cur.addr));
                    check(mem_wr == cur.wr, "mem_wr", 32'(mem_wr), 32'(cur.wr));
                    check(mem_wdata == cur.wdata, "mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
                    check({ic_done, dc_done} == 2'b00, "grant_no_done", 32'({ic_done, dc_done}), 32'd0);
                    cmdCycles++;
                    if (mem_done) begin
                        if (cur.wr) refMem[cur.addr] = cur.wdata;
                        else expData = refRead(cur.addr);
                        ph = PH_RESP;
                    end else if (cmdCycles > 20) begin
                        check(1'b0, "grant_timeout", 32'(cmdCycles), 32'd20);
                        ph = PH_FREE;
                    end
                end
                default: begin
                    if (curOwner == DC)
                        check({ic_done, dc_done} == 2'b01, "dc_done_pulse", 32'({ic_done, dc_done}), 32'd1);
                    else
                        check({ic_done, dc_done} == 2'b10, "ic_done_pulse", 32'({ic_done, dc_done}), 32'd2);
                    check(mem_req == 1'b0 && busy == 1'b1, "resp_req_busy", 32'({mem_req, busy}), 32'd1);
                    if (!cur.wr)
                        check(ic_rdata == expData && dc_rdata == expData, "rdata",
                              32'({ic_rdata, dc_rdata}), 32'({expData, expData}));
                    svcOrder.push_back(dc_done ? DC : IC);
                    ph = PH_FREE;
                end
            endcase
        end
    end

    task automatic icRun(input int n, input int maxGap, input logic [AW-1:0] addr, input bit useFixed);
        int gap;
        int lat;
        for (int i = 0; i < n; i++) begin
            ic_addr = useFixed ? addr : randAddr();
            ic_req  = 1'b1;
            icExp.push_back('{wr: 1'b0, addr: ic_addr, wdata: '0});
            lat = 0;
            @(negedge clk);
            while (!ic_done && lat < 100) begin
                lat++;
                @(negedge clk);
            end
            check(ic_done, "ic_done_timeout", 32'(ic_done), 32'd1);
            icLat    = lat;
            icRdLast = ic_rdata;
            @(posedge clk); #1;
            gap = int'($urandom_range(0, maxGap));
            if (gap > 0 || i == n - 1) begin
                ic_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
    endtask

    task automatic dcRun(input int n, input int maxGap, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input bit useFixed);
        int gap;
        int lat;
        for (int i = 0; i < n; i++) begin
            dc_wr    = useFixed ? wr : 1'($urandom_range(0, 1));
            dc_addr  = useFixed ? addr : randAddr();
            dc_wdata = useFixed ? wdata : DW'($urandom);
            dc_req   = 1'b1;
            dcExp.push_back('{wr: dc_wr, addr: dc_addr, wdata: dc_wdata});
            lat = 0;
            @(negedge clk);
            while (!dc_done && lat < 100) begin
                lat++;
                @(negedge clk);
            end
            check(dc_done, "dc_done_timeout", 32'(dc_done), 32'd1);
            dcLat = lat;
            @(posedge clk); #1;
            gap = int'($urandom_range(0, maxGap));
            if (gap > 0 || i == n - 1) begin
                dc_req = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
    endtask

    initial begin : main
        int ic0;
        int dc0;
        int exp040 [8];
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp040 = '{DC, IC, DC, IC, DC, IC, DC, IC};
`else
        exp040 = '{DC, DC, DC, DC, IC, IC, IC, IC};
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Single I-cache read, 3 stall cycles.
        memArr[16'h0040] = 16'h1234;
        refMem[16'h0040] = 16'h1234;
        forcedStall = 3;
        icRun(1, 0, 16'h0040, 1'b1);
        check(icLat == 5, "ic_read_latency", 32'(icLat), 32'd5);
        check(icRdLast == 16'h1234, "ic_read_data", 32'(icRdLast), 32'h1234);
        repeat (2) begin @(posedge clk); #1; end

        // D-cache write, no stall.
        forcedStall = 0;
        dcRun(1, 0, 1'b1, 16'h0100, 16'hBEEF, 1'b1);
        check(dcLat == 2, "dc_write_latency", 32'(dcLat), 32'd2);
        forcedStall = -1;
        repeat (2) begin @(posedge clk); #1; end

        // Fresh reset, then two ties: D-cache first each time.
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        svcOrder.delete();
        fork
            icRun(1, 0, '0, 1'b0);
            dcRun(1, 0, 1'b0, '0, '0, 1'b0);
        join
        repeat (2) begin @(posedge clk); #1; end
        fork
            icRun(1, 0, '0, 1'b0);
            dcRun(1, 0, 1'b0, '0, '0, 1'b0);
        join
        check(svcOrder.size() == 4, "tie_count", 32'(svcOrder.size()), 32'd4);
        for (int k = 0; k < 4 && k < svcOrder.size(); k++)
            check(svcOrder[k] == ((k % 2 == 0) ? DC : IC), "tie_order", 32'(svcOrder[k]),
                  32'((k % 2 == 0) ? DC : IC));
        repeat (2) begin @(posedge clk); #1; end

        // Continuous re-requests from both sides.
        svcOrder.delete();
        fork
            icRun(4, 0, '0, 1'b0);
            dcRun(4, 0, 1'b0, '0, '0, 1'b0);
        join
        check(svcOrder.size() == 8, "cont_count", 32'(svcOrder.size()), 32'd8);
        for (int k = 0; k < 8 && k < svcOrder.size(); k++)
            check(svcOrder[k] == exp040[k], "cont_order", 32'(svcOrder[k]), 32'(exp040[k]));
        repeat (2) begin @(posedge clk); #1; end

        // Reset while in GRANT, then a stale mem_done.
        memAuto = 1'b0;
        ic_addr = 16'h0300;
        ic_req  = 1'b1;
        icExp.push_back('{wr: 1'b0, addr: 16'h0300, wdata: '0});
        for (int k = 0; k < 20 && !mem_req; k++) begin @(posedge clk); #1; end
        check(mem_req == 1'b1, "abort_grant_reached", 32'(mem_req), 32'd1);
        ic0 = icDoneCnt;
        dc0 = dcDoneCnt;
        rst    = 1'b1;
        ic_req = 1'b0;
        #1;
        check(mem_req == 1'b0 && busy == 1'b0, "abort_async", 32'({mem_req, busy}), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        mem_done = 1'b1;
        @(posedge clk); #1;
        mem_done = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check(icDoneCnt == ic0 && dcDoneCnt == dc0, "abort_no_done",
              32'(icDoneCnt + dcDoneCnt), 32'(ic0 + dc0));
        memAuto = 1'b1;

        // D-cache request arriving mid I-cache GRANT; I-cache fields scrambled meanwhile.
        svcOrder.delete();
        forcedStall = 3;
        fork
            icRun(1, 0, 16'h0080, 1'b1);
            begin
                @(posedge clk); #1;
                ic_addr = '1;
                dcRun(1, 0, 1'b1, 16'h0200, 16'hCAFE, 1'b1);
            end
        join
        check(svcOrder.size() == 2 && svcOrder[0] == IC && svcOrder[1] == DC, "late_order",
              32'(svcOrder.size()), 32'd2);
        forcedStall = -1;
        repeat (2) begin @(posedge clk); #1; end

        // Randomized traffic.
        fork
            icRun(25, 3, '0, 1'b0);
            dcRun(25, 3, 1'b0, '0, '0, 1'b0);
        join
        repeat (10) begin @(posedge clk); #1; end
        check(icExp.size() == 0 && dcExp.size() == 0, "queues_drained",
              32'(icExp.size() + dcExp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
